riscv_multicycle_ctrl: RTL and testbench
========================================

// Module: riscv_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle RV64 datapath (RISCVCPU). Sequences fetch/decode/execute/mem/writeback.
//  Drives PC/IR/memory/ALU/regfile control strobes and the 4-bit stateNum debug bus.
//  Stretches memory states on a mem_ready handshake. Flags illegal opcodes.
//  Counts retired instructions.
// PARAMETERS
//  CNT_W        32  width of retired-instruction counter
//  MEM_WAIT_EN  1   1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  IR           in   32     current instruction (opcode [6:0], funct3 [14:12])
//  Zero         in   1      ALU zero flag (branch compare)
//  mem_ready    in   1      memory completes access this cycle
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load if Zero
//  IorD         out  1      0: address=PC; 1: address=ALUOut
//  MemRead      out  1      memory read strobe
//  MemWrite     out  1      memory write strobe
//  IRWrite      out  1      latch IR and OldPC
//  MemtoReg     out  1      0: regfile data=ALUOut; 1: MDR
//  RegWrite     out  1      regfile write enable
//  PCSource     out  1      0: PC<=ALUResult; 1: PC<=ALUOut
//  ALUSrcA      out  2      00 PC, 01 A, 10 OldPC
//  ALUSrcB      out  2      00 B, 01 const 4, 10 imm (I/S), 11 branch imm
//  ALUOp        out  2      00 add, 01 sub, 10 funct decode
//  stateNum     out  4      current state encoding
//  illegal      out  1      sticky illegal-instruction flag
//  retired      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Moore FSM; outputs decode from state (plus mem_ready in memory states). Unlisted strobes are 0, muxes are 00.
//  Reset (sync): next state FETCH, retired=0, illegal=0. While reset=1, all strobes are 0 and stateNum=0.
//  States / outputs / transitions:
//   0 FETCH : MemRead, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
//             IRWrite and PCWrite only when mem_ready. FETCH->DECODE on mem_ready, else stay.
//   1 DECODE: ALUSrcA=10, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
//             0000011/0100011->MEMADR, 0110011->EXEC, 0010011->EXECI.
//             1100011 with funct3=000->BRANCH. Anything else->ILLEGAL.
//   2 MEMADR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. ->MEMRD (load) / MEMWR (store).
//   3 MEMRD : MemRead, IorD=1. ->MEMWB on mem_ready, else stay.
//   4 MEMWB : RegWrite, MemtoReg=1. ->FETCH, retire.
//   5 MEMWR : MemWrite, IorD=1. MemWrite is held every stall cycle. ->FETCH on mem_ready, retire.
//   6 EXEC  : ALUSrcA=01, ALUSrcB=00, ALUOp=10. ->RWB.
//   9 EXECI : ALUSrcA=01, ALUSrcB=10, ALUOp=10. ->RWB.
//   7 RWB   : RegWrite, MemtoReg=0. ->FETCH, retire.
//   8 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=1. ->FETCH, retire.
//  15 ILLEGAL: all strobes 0. illegal<=1. Stays until reset.
//  Encodings 10-14 are unused. Treat them as ILLEGAL.
//  Latency (mem_ready=1): R/I 4 cycles, ld 5, sd 4, beq 3.
//  retired: +1 on the retiring transition. Wraps at 2^CNT_W-1 -> 0 with no flag.
//  A stall never repeats IRWrite/PCWrite. Exactly one PC increment per fetched instruction.
//  Reset mid-instruction: abandons the instruction; no retire and no further strobes after the reset cycle.
//  mem_ready outside FETCH/MEMRD/MEMWR is ignored.
// STRUCTURE
//  Package riscv_ctrl_pkg holds:
//   - state_t (4-bit enum, values above);
//   - opcode constants OP_LOAD/OP_STORE/OP_RTYPE/OP_ITYPE/OP_BRANCH;
//   - ALUOp/ALUSrcA/ALUSrcB encoding localparams.
//  One combinational sub-module, riscv_opcode_class (IR -> {is_ld, is_sd, is_r, is_i, is_beq, is_bad}).
//  State register, retired counter and illegal flag live in the top.
// TESTING
//  add x3,x1,x2 (IR=0x002081B3), mem_ready=1 -> stateNum 0,1,6,7,0; RegWrite only in 7; retired=1.
//  ld x5,8(x0) (0x00803283), mem_ready low 2 cycles in MEMRD -> 0,1,2,3,3,3,4,0; MemRead in all 3s; retired+1.
//  sd x5,16(x0) (0x00503823), FETCH stalled 3 cycles -> IRWrite/PCWrite once only; MemWrite in 5; MemtoReg never 1.
//  beq x0,x0,0 (0x00000063), Zero=1 -> 0,1,8,0; PCWriteCond=1 and PCSource=1 in 8; retired+1.
//  IR=0xFFFFFFFF -> 0,1,15, then holds 15 with illegal=1 and no strobes; reset=1 one cycle -> stateNum=0, illegal=0, retired=0.
//  CNT_W=4: 16 back-to-back adds -> retired wraps 15->0. Reset asserted in MEMADR -> FETCH next, retired unchanged.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - state encoding, opcodes and mux/ALU encodings for the multicycle control FSM
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_EXECI   = 4'd9,
    S_ILLEGAL = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  // True on the cycle whose transition completes an instruction.
  function automatic logic retires(state_t s, logic mem_ok);
    case (s)
      S_MEMWB, S_RWB, S_BRANCH: return 1'b1;
      S_MEMWR:                  return mem_ok;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_opcode_class.sv
// rtl/riscv_opcode_class.sv - classifies the current instruction into the FSM's dispatch groups
module riscv_opcode_class
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] IR,
  output logic        is_ld,
  output logic        is_sd,
  output logic        is_r,
  output logic        is_i,
  output logic        is_beq,
  output logic        is_bad
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_ir_bits;

  assign opcode = IR[6:0];
  assign funct3 = IR[14:12];
  assign unused_ir_bits = ^{IR[31:15], IR[11:7]};

  assign is_ld  = (opcode == OP_LOAD);
  assign is_sd  = (opcode == OP_STORE);
  assign is_r   = (opcode == OP_RTYPE);
  assign is_i   = (opcode == OP_ITYPE);
  // Only beq is implemented; other branch funct3 values trap.
  assign is_beq = (opcode == OP_BRANCH) && (funct3 == 3'b000);
  assign is_bad = ~(is_ld | is_sd | is_r | is_i | is_beq);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - Moore control FSM sequencing fetch/decode/execute/mem/writeback
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             PCSource,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       stateNum,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t state, next_state;
  logic   is_ld, is_sd, is_r, is_i, is_beq, is_bad;
  logic   mem_ok, retire_now, unused_zero;

  riscv_opcode_class u_class (
    .IR    (IR),
    .is_ld (is_ld),
    .is_sd (is_sd),
    .is_r  (is_r),
    .is_i  (is_i),
    .is_beq(is_beq),
    .is_bad(is_bad)
  );

  // Zero is combined with PCWriteCond in the datapath, not here.
  assign unused_zero = Zero;
  assign mem_ok      = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign retire_now  = retires(state, mem_ok);
  assign stateNum    = reset ? 4'd0 : state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (retire_now) retired <= retired + CNT_W'(1);
      if (next_state == S_ILLEGAL) illegal <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          // IR/PC latch only on the completing cycle so a stall never double-increments.
          IRWrite = mem_ok;
          PCWrite = mem_ok;
          if (mem_ok) next_state = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_BRIMM;
          if (is_bad)              next_state = S_ILLEGAL;
          else if (is_ld || is_sd) next_state = S_MEMADR;
          else if (is_r)           next_state = S_EXEC;
          else if (is_i)           next_state = S_EXECI;
          else                     next_state = S_BRANCH;
        end
        S_MEMADR: begin
          ALUSrcA    = SRCA_REG;
          ALUSrcB    = SRCB_IMM;
          next_state = is_ld ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ok) next_state = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ok) next_state = S_FETCH;
        end
        S_EXEC: begin
          ALUSrcA    = SRCA_REG;
          ALUSrcB    = SRCB_REG;
          ALUOp      = ALUOP_FUNCT;
          next_state = S_RWB;
        end
        S_EXECI: begin
          ALUSrcA    = SRCA_REG;
          ALUSrcB    = SRCB_IMM;
          ALUOp      = ALUOP_FUNCT;
          next_state = S_RWB;
        end
        S_RWB: begin
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA     = SRCA_REG;
          ALUSrcB     = SRCB_REG;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 1'b1;
          next_state  = S_FETCH;
        end
        default: next_state = S_ILLEGAL;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb/tb_riscv_multicycle_ctrl.sv - scoreboard bench: per-cycle expected control vectors from an instruction-level model
module tb_riscv_multicycle_ctrl;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IR = 32'h0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, PCSource, illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0]  stateNum;
  logic [CNT_W-1:0] retired;

  riscv_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .IR(IR), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .stateNum(stateNum), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0]      sig;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [CNT_W-1:0] m_ret = '0;
  logic        m_ill = 1'b0;
  logic [31:0] cur_ir = 32'h0;
  int          cur_reset_at, idx;
  bit          aborted;

  // Phase table: which strobes each phase asserts (stateNum is the phase number).
  function automatic logic [14:0] exp_strobes(input int st, input logic rdy);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, pcs;
    logic [1:0] sa, sb, op;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rw, pcs} = '0;
    sa = 2'b00; sb = 2'b00; op = 2'b00;
    case (st)
      0: begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1: begin sa = 2'b10; sb = 2'b11; end
      2: begin sa = 2'b01; sb = 2'b10; end
      3: begin mr = 1'b1; iord = 1'b1; end
      4: begin rw = 1'b1; m2r = 1'b1; end
      5: begin mw = 1'b1; iord = 1'b1; end
      6: begin sa = 2'b01; op = 2'b10; end
      7: rw = 1'b1;
      8: begin sa = 2'b01; op = 2'b01; pcwc = 1'b1; pcs = 1'b1; end
      9: begin sa = 2'b01; sb = 2'b10; op = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, pcs, sa, sb, op};
  endfunction

  task automatic add_cycle(input logic rst, input logic rdy, input int st);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    IR        = cur_ir;
    Zero      = 1'($urandom);
    e.sig = rst ? {19'b0, m_ill} : {exp_strobes(st, rdy), 4'(st), m_ill};
    e.ret = m_ret;
    exp_q.push_back(e);
    if (rst) begin
      m_ret = '0;
      m_ill = 1'b0;
    end
  endtask

  task automatic step(input int st, input logic rdy);
    if (aborted) return;
    if (idx == cur_reset_at) begin
      add_cycle(1'b1, rdy, 0);
      aborted = 1'b1;
    end else begin
      add_cycle(1'b0, rdy, st);
    end
    idx++;
  endtask

  task automatic mem_phase(input int st, input int stalls);
    for (int s = 0; s < stalls; s++) step(st, 1'b0);
    step(st, 1'b1);
  endtask

  // One instruction: phases follow from the opcode; reset_at<0 means no reset.
  task automatic do_instr(input logic [31:0] ir, input int fstall, input int mstall,
                          input int reset_at, input int hold);
    logic [6:0] opc;
    logic [2:0] f3;
    cur_ir = ir; cur_reset_at = reset_at; idx = 0; aborted = 1'b0;
    opc = ir[6:0];
    f3  = ir[14:12];
    mem_phase(0, fstall);
    step(1, 1'($urandom));
    if (opc == 7'b0000011) begin
      step(2, 1'($urandom)); mem_phase(3, mstall); step(4, 1'($urandom));
    end else if (opc == 7'b0100011) begin
      step(2, 1'($urandom)); mem_phase(5, mstall);
    end else if (opc == 7'b0110011) begin
      step(6, 1'($urandom)); step(7, 1'($urandom));
    end else if (opc == 7'b0010011) begin
      step(9, 1'($urandom)); step(7, 1'($urandom));
    end else if (opc == 7'b1100011 && f3 == 3'b000) begin
      step(8, 1'($urandom));
    end else begin
      if (!aborted) m_ill = 1'b1;
      for (int h = 0; h < hold; h++) step(15, 1'($urandom));
      if (!aborted) begin
        add_cycle(1'b1, 1'($urandom), 0);
        aborted = 1'b1;
      end
    end
    if (!aborted) m_ret = m_ret + 1'b1;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[6:0] = 7'b0000011;
      1: r[6:0] = 7'b0100011;
      2: r[6:0] = 7'b0110011;
      3: r[6:0] = 7'b0010011;
      4: begin r[6:0] = 7'b1100011; r[14:12] = 3'b000; end
      5: begin r[6:0] = 7'b1100011; if (r[14:12] == 3'b000) r[14:12] = 3'b001; end
      default: ;
    endcase
    return r;
  endfunction

  exp_t mon_e;
  logic [19:0] act_sig;
  assign act_sig = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp, stateNum, illegal};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (act_sig !== mon_e.sig || retired !== mon_e.ret) begin
        miscompares++;
        $display("FAIL ctrl_vec #%0d: got sig=%h stateNum=%0d retired=%0d, want sig=%h stateNum=%0d retired=%0d",
                 vectors, act_sig, stateNum, retired, mon_e.sig, mon_e.sig[4:1], mon_e.ret);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    @(posedge clk);
    add_cycle(1'b1, 1'b0, 0);
    do_instr(32'h002081B3, 0, 0, -1, 0);
    do_instr(32'h00803283, 0, 2, -1, 0);
    do_instr(32'h00503823, 3, 0, -1, 0);
    do_instr(32'h00000063, 0, 0, -1, 0);
    do_instr(32'hFFFFFFFF, 0, 0, -1, 3);
    repeat (16) do_instr(32'h002081B3, 0, 0, -1, 0);
    do_instr(32'h00803283, 0, 0, 2, 0);
    for (int n = 0; n < 300; n++) begin
      do_instr(rand_ir(), $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 11) == 0) ? $urandom_range(0, 6) : -1,
               $urandom_range(1, 3));
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never observed, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
